// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS-subset core: opcodes, funct codes, ALU ops.
package cpu_pkg;

   localparam int DATA_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT
   } alu_op_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the EX stage; arithmetic wraps modulo 2^32, no overflow traps.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  alu_op_t                  alu_op,
   output logic signed [DATA_W-1:0] y,
   output logic                     neg
);

   // Select the result for the requested operation
   always_comb begin
      y = '0;
      case (alu_op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_NOR: y = ~(a | b);
         ALU_SLT: y[0] = (a < b);
         default: y = '0;
      endcase
   end

   assign neg = y[DATA_W-1];

endmodule

// File: rtl/cpu.sv
// Five-stage MIPS-subset core fed one instruction per clock; full forwarding, never stalls.
module cpu
   import cpu_pkg::*;
#(
   parameter int DM_WORDS = 64
)(
   input  logic        clock,
   input  logic        start,
   input  logic [31:0] i_datain
);

   localparam int AW = $clog2(DM_WORDS);

   logic [31:0] pcf;
   logic [31:0] d_datain;
   logic [31:0] gr [0:31];
   logic [31:0] dm [0:DM_WORDS-1];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, dst_d;
   logic [31:0] imm_ext, rs_val_d, rt_val_d;
   alu_op_t     alu_op_d;
   logic        use_imm_d, wen_d, load_d, store_d;

   alu_op_t     alu_op_p1;
   logic        use_imm_p1, wen_p1, load_p1, store_p1;
   logic [4:0]  rs_p1, rt_p1, dst_p1;
   logic [31:0] rs_val_p1, rt_val_p1, imm_p1;

   logic signed [DATA_W-1:0] fwd_a, fwd_b, alu_b, aluOutE;
   logic        nf;

   logic        wen_p2, load_p2, store_p2;
   logic [4:0]  dst_p2;
   logic [31:0] alu_p2, sdata_p2;
   logic [AW-1:0] dm_idx;
   logic [31:0] dm_rdata, mem_result;

   logic        wen_p3;
   logic [4:0]  dst_p3;
   logic [31:0] result_p3;

   // pcf and nf are observation points only; shamt has no use in this subset
   logic unused_sink;
   assign unused_sink = ^{pcf, nf, d_datain[10:6]};

   // IF: latch the incoming instruction and advance the informational PC
   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         pcf      <= '0;
         d_datain <= '0;
      end else begin
         pcf      <= pcf + 32'd4;
         d_datain <= i_datain;
      end
   end

   // ID: field extraction and register read with same-cycle WB bypass
   assign op       = d_datain[31:26];
   assign rs       = d_datain[25:21];
   assign rt       = d_datain[20:16];
   assign rd       = d_datain[15:11];
   assign funct    = d_datain[5:0];
   assign imm_ext  = {{16{d_datain[15]}}, d_datain[15:0]};
   assign rs_val_d = (wen_p3 && dst_p3 == rs) ? result_p3 : gr[rs];
   assign rt_val_d = (wen_p3 && dst_p3 == rt) ? result_p3 : gr[rt];

   // Decode; unknown encodings become NOPs, and a destination of r0 disables the write
   always_comb begin
      alu_op_d  = ALU_ADD;
      use_imm_d = 1'b0;
      wen_d     = 1'b0;
      load_d    = 1'b0;
      store_d   = 1'b0;
      dst_d     = rd;
      case (op)
         OP_LW:   begin use_imm_d = 1'b1; wen_d = 1'b1; load_d = 1'b1; dst_d = rt; end
         OP_SW:   begin use_imm_d = 1'b1; store_d = 1'b1; end
         OP_ADDI: begin use_imm_d = 1'b1; wen_d = 1'b1; dst_d = rt; end
         OP_RTYPE: begin
            wen_d = 1'b1;
            case (funct)
               F_ADD, F_ADDU: alu_op_d = ALU_ADD;
               F_SUB, F_SUBU: alu_op_d = ALU_SUB;
               F_AND:         alu_op_d = ALU_AND;
               F_OR:          alu_op_d = ALU_OR;
               F_XOR:         alu_op_d = ALU_XOR;
               F_NOR:         alu_op_d = ALU_NOR;
               F_SLT:         alu_op_d = ALU_SLT;
               default:       wen_d    = 1'b0;
            endcase
         end
         default: ;
      endcase
      if (dst_d == 5'd0) wen_d = 1'b0;
   end

   // ID/EX pipeline register
   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         alu_op_p1 <= ALU_ADD;
         use_imm_p1 <= 1'b0;
         wen_p1    <= 1'b0;
         load_p1   <= 1'b0;
         store_p1  <= 1'b0;
         rs_p1     <= '0;
         rt_p1     <= '0;
         dst_p1    <= '0;
         rs_val_p1 <= '0;
         rt_val_p1 <= '0;
         imm_p1    <= '0;
      end else begin
         alu_op_p1 <= alu_op_d;
         use_imm_p1 <= use_imm_d;
         wen_p1    <= wen_d;
         load_p1   <= load_d;
         store_p1  <= store_d;
         rs_p1     <= rs;
         rt_p1     <= rt;
         dst_p1    <= dst_d;
         rs_val_p1 <= rs_val_d;
         rt_val_p1 <= rt_val_d;
         imm_p1    <= imm_ext;
      end
   end

   // EX: operand forwarding, EX/MEM ahead of MEM/WB ahead of the register-file copy
   always_comb begin
      fwd_a = rs_val_p1;
      if (wen_p2 && dst_p2 == rs_p1)      fwd_a = mem_result;
      else if (wen_p3 && dst_p3 == rs_p1) fwd_a = result_p3;
      fwd_b = rt_val_p1;
      if (wen_p2 && dst_p2 == rt_p1)      fwd_b = mem_result;
      else if (wen_p3 && dst_p3 == rt_p1) fwd_b = result_p3;
   end

   assign alu_b = use_imm_p1 ? imm_p1 : fwd_b;

   cpu_alu u_alu (
      .a      (fwd_a),
      .b      (alu_b),
      .alu_op (alu_op_p1),
      .y      (aluOutE),
      .neg    (nf)
   );

   // EX/MEM pipeline register; store data is the forwarded rt value
   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         wen_p2   <= 1'b0;
         load_p2  <= 1'b0;
         store_p2 <= 1'b0;
         dst_p2   <= '0;
         alu_p2   <= '0;
         sdata_p2 <= '0;
      end else begin
         wen_p2   <= wen_p1;
         load_p2  <= load_p1;
         store_p2 <= store_p1;
         dst_p2   <= dst_p1;
         alu_p2   <= aluOutE;
         sdata_p2 <= fwd_b;
      end
   end

   // MEM: combinational read so a load result can be forwarded from this stage
   assign dm_idx     = alu_p2[AW-1:0];
   assign dm_rdata   = dm[dm_idx];
   assign mem_result = load_p2 ? dm_rdata : alu_p2;

   // Data memory: reset restores the preloaded image, stores write on the edge
   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
         dm[1] <= 32'h0000_00ab;
         dm[2] <= 32'h0000_3c00;
      end else if (store_p2) begin
         dm[dm_idx] <= sdata_p2;
      end
   end

   // MEM/WB pipeline register
   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         wen_p3    <= 1'b0;
         dst_p3    <= '0;
         result_p3 <= '0;
      end else begin
         wen_p3    <= wen_p2;
         dst_p3    <= dst_p2;
         result_p3 <= mem_result;
      end
   end

   // WB: register file write; r0 is never written because decode drops such writes
   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         for (int i = 0; i < 32; i++) gr[i] <= '0;
      end else if (wen_p3) begin
         gr[dst_p3] <= result_p3;
      end
   end

endmodule

// File: tb/tb_cpu.sv
// Testbench for cpu: directed checks followed by random programs against an ISA-level model.
module tb_cpu;

   localparam int NR = 200;

   logic        clock = 1'b0;
   logic        start = 1'b1;
   logic [31:0] i_datain = '0;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_gr [32];
   logic [31:0] m_dm [64];
   logic [31:0] hist_gr [NR][32];
   logic [31:0] hist_dm [NR][64];
   logic [31:0] ins, acc;
   logic [5:0]  fn_tab [9];
   logic [5:0]  sw_fn [7];
   logic [31:0] sw_exp [7];

   cpu #(.DM_WORDS(64)) dut (
      .clock    (clock),
      .start    (start),
      .i_datain (i_datain)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt,
                                         input logic [5:0] fn);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic step(input logic [31:0] instr);
      i_datain = instr;
      @(posedge clock);
      #1;
   endtask

   task automatic mwr(input int r, input logic [31:0] v);
      if (r != 0) m_gr[r] = v;
   endtask

   // Architectural effect of one instruction, executed in program order
   task automatic model_exec(input logic [31:0] w);
      logic [31:0] a, b, imm, ea;
      int rs, rt, rd;
      rs  = int'(w[25:21]);
      rt  = int'(w[20:16]);
      rd  = int'(w[15:11]);
      a   = m_gr[rs];
      b   = m_gr[rt];
      imm = {{16{w[15]}}, w[15:0]};
      ea  = (a + imm) % 32'd64;
      case (w[31:26])
         6'b100011: mwr(rt, m_dm[ea]);
         6'b101011: m_dm[ea] = b;
         6'b001000: mwr(rt, a + imm);
         6'b000000: begin
            case (w[5:0])
               6'b100000, 6'b100001: mwr(rd, a + b);
               6'b100010, 6'b100011: mwr(rd, a - b);
               6'b100100: mwr(rd, a & b);
               6'b100101: mwr(rd, a | b);
               6'b100110: mwr(rd, a ^ b);
               6'b100111: mwr(rd, ~(a | b));
               6'b101010: mwr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
               default: ;
            endcase
         end
         default: ;
      endcase
   endtask

   function automatic logic [31:0] rand_instr();
      int k;
      k = $urandom_range(0, 9);
      if (k < 2)  return enc_i(6'b100011, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      if (k < 4)  return enc_i(6'b101011, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      if (k == 4) return enc_i(6'b001000, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      if (k < 9) begin
         logic [31:0] r;
         r = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   fn_tab[$urandom_range(0, 8)]);
         r[10:6] = 5'($urandom);
         return r;
      end
      if ($urandom_range(0, 1) == 0)
         return enc_r($urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'b000000);
      return enc_i(6'b001101, $urandom_range(0, 7), $urandom_range(1, 7), 16'($urandom));
   endfunction

   initial begin
      fn_tab = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                 6'b100101, 6'b100110, 6'b100111, 6'b101010};
      sw_fn  = '{6'b100000, 6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b100011, 6'b101010};
      sw_exp = '{32'h0000_3cab, 32'h0000_0000, 32'h0000_3cab, 32'hffff_c354,
                 32'h0000_3cab, 32'hffff_c4ab, 32'h0000_0001};

      // Reset state
      #2 start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("pcf_rst", dut.pcf, 32'd0);
      acc = '0;
      for (int i = 0; i < 32; i++) acc = acc | dut.gr[i];
      chk("gr_rst", acc, 32'd0);
      chk("dm0_rst", dut.dm[0], 32'd0);
      chk("dm1_rst", dut.dm[1], 32'h0000_00ab);
      chk("dm2_rst", dut.dm[2], 32'h0000_3c00);
      start = 1'b1;
      step(32'h0);
      chk("pcf_4", dut.pcf, 32'd4);
      step(32'h0);
      chk("pcf_8", dut.pcf, 32'd8);

      // Loads and write-back latency
      step(enc_i(6'b100011, 0, 1, 16'd1));
      step(enc_i(6'b100011, 0, 2, 16'd2));
      step(32'h0);
      step(32'h0);
      chk("lw_early", dut.gr[1], 32'd0);
      step(32'h0);
      chk("lw_gr1", dut.gr[1], 32'h0000_00ab);
      step(32'h0);
      chk("lw_gr2", dut.gr[2], 32'h0000_3c00);

      // Load-use with no stall
      step(enc_i(6'b100011, 0, 1, 16'd1));
      step(enc_i(6'b100011, 0, 2, 16'd2));
      step(enc_i(6'b100011, 0, 1, 16'd1));
      step(enc_i(6'b100011, 0, 2, 16'd2));
      step(enc_r(3, 1, 2, 6'b100010));
      step(32'h0);
      chk("lu_alu", dut.aluOutE, 32'hffff_c4ab);
      chk("lu_nf", {31'd0, dut.nf}, 32'd1);
      repeat (3) step(32'h0);
      chk("lu_gr3", dut.gr[3], 32'hffff_c4ab);

      // Logic/arith sweep
      for (int j = 0; j < 7; j++) begin
         step(enc_r(3, 1, 2, sw_fn[j]));
         repeat (4) step(32'h0);
         chk($sformatf("sweep_%0d", j), dut.gr[3], sw_exp[j]);
      end

      // Store then load the same word
      step(enc_i(6'b101011, 0, 2, 16'd5));
      step(enc_i(6'b100011, 0, 4, 16'd5));
      repeat (4) step(32'h0);
      chk("st_ld_gr4", dut.gr[4], 32'h0000_3c00);
      chk("st_dm5", dut.dm[5], 32'h0000_3c00);

      // Store data forwarded from the immediately preceding instruction
      step(enc_i(6'b001000, 0, 5, 16'h1234));
      step(enc_i(6'b101011, 0, 5, 16'd6));
      repeat (3) step(32'h0);
      chk("st_fwd_dm6", dut.dm[6], 32'h0000_1234);

      // Writes to r0 are dropped and never forwarded
      step(enc_r(0, 1, 2, 6'b100000));
      step(enc_r(3, 0, 1, 6'b100000));
      repeat (4) step(32'h0);
      chk("gr0_zero", dut.gr[0], 32'd0);
      chk("gr0_use", dut.gr[3], 32'h0000_00ab);

      // Reset mid-stream discards in-flight work and reloads DM
      step(enc_i(6'b001000, 0, 6, 16'd7));
      step(enc_i(6'b001000, 0, 7, 16'd9));
      #2 start = 1'b0;
      #1;
      chk("mid_pcf", dut.pcf, 32'd0);
      chk("mid_gr1", dut.gr[1], 32'd0);
      chk("mid_dm1", dut.dm[1], 32'h0000_00ab);
      chk("mid_dm5", dut.dm[5], 32'd0);
      @(posedge clock);
      #1;
      start = 1'b1;
      repeat (5) step(32'h0);
      chk("mid_gr6", dut.gr[6], 32'd0);
      chk("mid_gr7", dut.gr[7], 32'd0);

      // Random programs against the in-order model
      for (int i = 0; i < 32; i++) m_gr[i] = '0;
      for (int i = 0; i < 64; i++) m_dm[i] = '0;
      m_dm[1] = 32'h0000_00ab;
      m_dm[2] = 32'h0000_3c00;
      for (int n = 0; n < NR + 4; n++) begin
         ins = (n < NR) ? rand_instr() : 32'h0;
         if (n < NR) begin
            model_exec(ins);
            for (int i = 0; i < 32; i++) hist_gr[n][i] = m_gr[i];
            for (int i = 0; i < 64; i++) hist_dm[n][i] = m_dm[i];
         end
         step(ins);
         if (n >= 4)
            for (int i = 0; i < 32; i++)
               chk($sformatf("rnd%0d_gr%0d", n - 4, i), dut.gr[i], hist_gr[n-4][i]);
         if (n >= 3 && n - 3 < NR)
            for (int i = 0; i < 64; i++)
               chk($sformatf("rnd%0d_dm%0d", n - 3, i), dut.dm[i], hist_dm[n-3][i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
